// File: rtl/ss_pkg.sv
// Shared types and constants for the selectMAP configuration target.
package ss_pkg;

    localparam int unsigned SS_DATA_W = 32;
    localparam int unsigned SS_CNT_W  = 16;

    localparam logic [SS_DATA_W-1:0] SS_SYNC_WORD = 32'hAA995566;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_INIT,
        ST_WAIT_SYNC,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } ss_state_e;

    typedef struct packed {
        logic                 prog_b;
        logic                 cs_b;
        logic                 rdwr_b;
        logic [SS_DATA_W-1:0] d;
    } ss_cfg_t;

    // Idle bus: program asserted, chip deselected, read direction.
    localparam ss_cfg_t SS_CFG_IDLE = '{prog_b: 1'b0, cs_b: 1'b1, rdwr_b: 1'b1, d: '0};

    // Reverse bit order inside each byte (bit 0 <-> bit 7).
    function automatic logic [SS_DATA_W-1:0] ss_bitswap(input logic [SS_DATA_W-1:0] w);
        logic [SS_DATA_W-1:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[b*8 + i] = w[b*8 + 7 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ss_edge_sync.sv
// Two-flop synchroniser for the selectMAP pins plus a registered cclk rising-edge
// strobe; the remaining pins get one extra stage so they line up with the strobe.
module ss_edge_sync
    import ss_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    cclk_i,
    input  ss_cfg_t cfg_i,
    output logic    cclk_rise_o,
    output ss_cfg_t cfg_o
);

    logic    cclk_meta_q;
    logic    cclk_sync_q;
    logic    cclk_prev_q;
    logic    cclk_rise_q;
    ss_cfg_t cfg_meta_q;
    ss_cfg_t cfg_sync_q;
    ss_cfg_t cfg_algn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cclk_meta_q <= 1'b0;
            cclk_sync_q <= 1'b0;
            cclk_prev_q <= 1'b0;
            cclk_rise_q <= 1'b0;
            cfg_meta_q  <= SS_CFG_IDLE;
            cfg_sync_q  <= SS_CFG_IDLE;
            cfg_algn_q  <= SS_CFG_IDLE;
        end else begin
            cclk_meta_q <= cclk_i;
            cclk_sync_q <= cclk_meta_q;
            cclk_prev_q <= cclk_sync_q;
            cclk_rise_q <= cclk_sync_q & ~cclk_prev_q;
            cfg_meta_q  <= cfg_i;
            cfg_sync_q  <= cfg_meta_q;
            cfg_algn_q  <= cfg_sync_q;
        end
    end

    assign cclk_rise_o = cclk_rise_q;
    assign cfg_o       = cfg_algn_q;

endmodule

// File: rtl/ss_target.sv
// SelectMAP configuration target: init sequencing, sync-word hunt and word loading.
// Build option SS_TARGET_BITSWAP_EN reverses bits within each data byte.
module ss_target
    import ss_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 16,
    parameter int unsigned LOAD_WORDS  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_cclk,
    input  logic                 cfg_prog_b,
    input  logic                 cfg_cs_b,
    input  logic                 cfg_rdwr_b,
    input  logic [SS_DATA_W-1:0] cfg_d,
    output logic                 cfg_init_b,
    output logic                 cfg_done,
    output logic                 word_valid,
    output logic [SS_DATA_W-1:0] word_data,
    output logic [SS_CNT_W-1:0]  word_count,
    output logic                 sync_seen,
    output logic                 err
);

    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0]   INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [SS_CNT_W-1:0] LOAD_LAST = SS_CNT_W'(LOAD_WORDS);

    ss_cfg_t              cfg_raw;
    ss_cfg_t              cfg_s;
    logic                 rise_s;
    logic [SS_DATA_W-1:0] word_in;
    logic                 accept;
    logic                 read_req;
    logic [SS_CNT_W-1:0]  count_inc;

    ss_state_e            state_q,    state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    logic                 init_b_q,   init_b_d;
    logic                 done_q,     done_d;
    logic                 valid_q,    valid_d;
    logic [SS_DATA_W-1:0] data_q,     data_d;
    logic [SS_CNT_W-1:0]  count_q,    count_d;
    logic                 sync_q,     sync_d;
    logic                 err_q,      err_d;

    assign cfg_raw = '{prog_b: cfg_prog_b, cs_b: cfg_cs_b, rdwr_b: cfg_rdwr_b, d: cfg_d};

    ss_edge_sync u_edge_sync (
        .clk         (clk),
        .rst         (rst),
        .cclk_i      (cfg_cclk),
        .cfg_i       (cfg_raw),
        .cclk_rise_o (rise_s),
        .cfg_o       (cfg_s)
    );

`ifdef SS_TARGET_BITSWAP_EN
    assign word_in = ss_bitswap(cfg_s.d);
`else
    assign word_in = cfg_s.d;
`endif

    assign accept    = rise_s & ~cfg_s.cs_b & ~cfg_s.rdwr_b;
    assign read_req  = rise_s & ~cfg_s.cs_b &  cfg_s.rdwr_b;
    assign count_inc = count_q + SS_CNT_W'(1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            init_cnt_q <= '0;
            init_b_q   <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            count_q    <= '0;
            sync_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            init_b_q   <= init_b_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            count_q    <= count_d;
            sync_q     <= sync_d;
            err_q      <= err_d;
        end
    end

    // Next state; a low program pin overrides everything, including a same-cycle word.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_b_d   = init_b_q;
        done_d     = done_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        count_d    = count_q;
        sync_d     = sync_q;
        err_d      = err_q;

        if (!cfg_s.prog_b) begin
            state_d    = ST_RESET;
            init_cnt_d = '0;
            init_b_d   = 1'b0;
            done_d     = 1'b0;
            count_d    = '0;
            sync_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
                ST_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d  = ST_WAIT_SYNC;
                        init_b_d = 1'b1;
                    end else begin
                        init_cnt_d = init_cnt_q + INIT_W'(1);
                    end
                end
                ST_WAIT_SYNC: begin
                    if (accept) begin
                        valid_d = 1'b1;
                        data_d  = word_in;
                        if (word_in == SS_SYNC_WORD) begin
                            sync_d  = 1'b1;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        valid_d = 1'b1;
                        data_d  = word_in;
                        if (count_q < LOAD_LAST) begin
                            count_d = count_inc;
                        end
                        if (count_inc >= LOAD_LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (read_req) begin
                        state_d  = ST_ERROR;
                        err_d    = 1'b1;
                        init_b_d = 1'b0;
                    end
                end
                ST_DONE, ST_ERROR: begin
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    assign cfg_init_b = init_b_q;
    assign cfg_done   = done_q;
    assign word_valid = valid_q;
    assign word_data  = data_q;
    assign word_count = count_q;
    assign sync_seen  = sync_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ss_target.sv
// Directed bench for ss_target (LOAD_WORDS=4); expectations follow SS_TARGET_BITSWAP_EN.
module tb_ss_target;

    localparam int unsigned INIT_CYCLES = 16;
    localparam int unsigned LOAD_WORDS  = 4;
    // Pin-to-FSM latency: two synchroniser flops plus the edge-strobe stage.
    localparam int unsigned SYNC_LAT    = 3;
    localparam logic [31:0] SYNC_WORD   = 32'hAA995566;
`ifdef SS_TARGET_BITSWAP_EN
    localparam logic [31:0] BUS_SYNC    = 32'h5599AA66;
    localparam logic [31:0] SWAP_SYNCS  = 32'd1;
    localparam logic [31:0] SWAP_DATA   = 32'hAA995566;
`else
    localparam logic [31:0] BUS_SYNC    = 32'hAA995566;
    localparam logic [31:0] SWAP_SYNCS  = 32'd0;
    localparam logic [31:0] SWAP_DATA   = 32'h5599AA66;
`endif
    // Byte-palindromic payloads read the same with or without the byte bit-swap.
    localparam logic [31:0] W0 = 32'h81A55A3C;
    localparam logic [31:0] W1 = 32'h186699E7;
    localparam logic [31:0] W2 = 32'h0000FFFF;
    localparam logic [31:0] W3 = 32'h24DBC3BD;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_cclk;
    logic        cfg_prog_b;
    logic        cfg_cs_b;
    logic        cfg_rdwr_b;
    logic [31:0] cfg_d;
    logic        cfg_init_b;
    logic        cfg_done;
    logic        word_valid;
    logic [31:0] word_data;
    logic [15:0] word_count;
    logic        sync_seen;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    int unsigned vcount   = 0;
    logic [31:0] last_data = '0;

    ss_target #(.INIT_CYCLES(INIT_CYCLES), .LOAD_WORDS(LOAD_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_cclk   (cfg_cclk),
        .cfg_prog_b (cfg_prog_b),
        .cfg_cs_b   (cfg_cs_b),
        .cfg_rdwr_b (cfg_rdwr_b),
        .cfg_d      (cfg_d),
        .cfg_init_b (cfg_init_b),
        .cfg_done   (cfg_done),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_count (word_count),
        .sync_seen  (sync_seen),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid === 1'b1) begin
            vcount    <= vcount + 1;
            last_data <= word_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cclk_word(input logic [31:0] d, input logic cs_b, input logic rdwr_b);
        cfg_d      = d;
        cfg_cs_b   = cs_b;
        cfg_rdwr_b = rdwr_b;
        tick(2);
        cfg_cclk = 1'b1;
        tick(5);
        cfg_cclk = 1'b0;
        tick(5);
    endtask

    task automatic reinit();
        cfg_prog_b = 1'b0;
        tick(6);
        cfg_prog_b = 1'b1;
        tick(SYNC_LAT + INIT_CYCLES + 6);
    endtask

    initial begin
        int unsigned v0;
        int unsigned lowcnt;
        logic        seen_high;

        rst        = 1'b1;
        cfg_cclk   = 1'b0;
        cfg_prog_b = 1'b0;
        cfg_cs_b   = 1'b1;
        cfg_rdwr_b = 1'b1;
        cfg_d      = '0;
        tick(4);
        check("rst_init_b",  32'(cfg_init_b), 32'd0);
        check("rst_done",    32'(cfg_done),   32'd0);
        check("rst_valid",   32'(word_valid), 32'd0);
        check("rst_data",    word_data,       32'd0);
        check("rst_count",   32'(word_count), 32'd0);
        check("rst_sync",    32'(sync_seen),  32'd0);
        check("rst_err",     32'(err),        32'd0);

        rst = 1'b0;
        tick(10);
        check("hold_reset_init_b", 32'(cfg_init_b), 32'd0);
        v0 = vcount;
        cclk_word(BUS_SYNC, 1'b0, 1'b0);
        check("reset_edge_ignored", 32'(vcount - v0), 32'd0);
        check("reset_no_sync",      32'(sync_seen),   32'd0);

        // Program pulse, then count the cycles init_b stays low.
        tick(5);
        cfg_prog_b = 1'b1;
        lowcnt    = 0;
        seen_high = 1'b0;
        for (int i = 0; i < 60 && !seen_high; i++) begin
            tick(1);
            if (cfg_init_b === 1'b1) seen_high = 1'b1;
            else lowcnt++;
        end
        check("init_b_rose",     32'(seen_high), 32'd1);
        check("init_low_cycles", 32'(lowcnt),    32'(SYNC_LAT + INIT_CYCLES));

        v0 = vcount;
        cclk_word(32'hFFFFFFFF, 1'b0, 1'b0);
        check("nosync_pulse", 32'(vcount - v0), 32'd1);
        check("nosync_data",  last_data,        32'hFFFFFFFF);
        check("nosync_flag",  32'(sync_seen),   32'd0);
        check("nosync_err",   32'(err),         32'd0);
        cclk_word(BUS_SYNC, 1'b0, 1'b0);
        check("sync_pulse", 32'(vcount - v0), 32'd2);
        check("sync_data",  last_data,        SYNC_WORD);
        check("sync_flag",  32'(sync_seen),   32'd1);
        check("sync_count", 32'(word_count),  32'd0);

        // Exact strobe latency: word_valid lands three edges after cclk is first sampled high.
        cfg_d      = W0;
        cfg_cs_b   = 1'b0;
        cfg_rdwr_b = 1'b0;
        tick(2);
        cfg_cclk = 1'b1;
        tick(3);
        check("lat_early", 32'(word_valid), 32'd0);
        tick(1);
        check("lat_valid", 32'(word_valid), 32'd1);
        check("lat_data",  word_data,       W0);
        tick(1);
        check("lat_single", 32'(word_valid), 32'd0);
        tick(2);
        cfg_cclk = 1'b0;
        tick(5);
        check("load_count1", 32'(word_count), 32'd1);
        cclk_word(W1, 1'b0, 1'b0);
        check("load_count2", 32'(word_count), 32'd2);

        v0 = vcount;
        cclk_word(W2, 1'b0, 1'b1);
        check("rd_err",     32'(err),          32'd1);
        check("rd_init_b",  32'(cfg_init_b),   32'd0);
        check("rd_count",   32'(word_count),   32'd2);
        check("rd_novalid", 32'(vcount - v0),  32'd0);
        cclk_word(W3, 1'b0, 1'b0);
        check("err_hold_novalid", 32'(vcount - v0), 32'd0);
        check("err_sticky",       32'(err),         32'd1);

        cfg_prog_b = 1'b0;
        tick(SYNC_LAT);
        check("prog_lat_err", 32'(err), 32'd1);
        tick(1);
        check("prog_clr_err",   32'(err),        32'd0);
        check("prog_clr_sync",  32'(sync_seen),  32'd0);
        check("prog_clr_count", 32'(word_count), 32'd0);
        check("prog_clr_init",  32'(cfg_init_b), 32'd0);

        // Reconfigure, then drop program together with a cclk edge mid-load.
        cfg_prog_b = 1'b1;
        tick(SYNC_LAT + INIT_CYCLES + 6);
        check("reinit_init_b", 32'(cfg_init_b), 32'd1);
        cclk_word(BUS_SYNC, 1'b0, 1'b0);
        cclk_word(W0, 1'b0, 1'b0);
        cclk_word(W1, 1'b0, 1'b0);
        check("mid_count", 32'(word_count), 32'd2);
        v0         = vcount;
        cfg_d      = W2;
        tick(2);
        cfg_cclk   = 1'b1;
        cfg_prog_b = 1'b0;
        tick(6);
        check("race_novalid", 32'(vcount - v0), 32'd0);
        check("race_count",   32'(word_count),  32'd0);
        check("race_sync",    32'(sync_seen),   32'd0);
        cfg_cclk = 1'b0;
        tick(3);

        cfg_prog_b = 1'b1;
        tick(SYNC_LAT + INIT_CYCLES + 6);
        cclk_word(BUS_SYNC, 1'b0, 1'b0);
        cclk_word(W0, 1'b0, 1'b0);
        cclk_word(W1, 1'b0, 1'b0);
        cclk_word(W2, 1'b0, 1'b0);
        check("pre_done", 32'(cfg_done), 32'd0);
        cclk_word(W3, 1'b0, 1'b0);
        check("done_flag",  32'(cfg_done),   32'd1);
        check("done_count", 32'(word_count), 32'd4);
        check("done_data",  last_data,       W3);
        check("done_init",  32'(cfg_init_b), 32'd1);
        v0 = vcount;
        cclk_word(W0, 1'b0, 1'b0);
        check("after_done_novalid", 32'(vcount - v0), 32'd0);
        check("after_done_count",   32'(word_count),  32'd4);
        check("after_done_flag",    32'(cfg_done),    32'd1);

        reinit();
        v0 = vcount;
        cclk_word(32'h5599AA66, 1'b0, 1'b0);
        check("swap_pulse", 32'(vcount - v0), 32'd1);
        check("swap_data",  last_data,        SWAP_DATA);
        check("swap_sync",  32'(sync_seen),   SWAP_SYNCS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ss_target.md
SS_TARGET -- requirements
Module: ss_target

Interface
REQ-001 Parameter INIT_CYCLES, default 16: clk cycles cfg_init_b stays low after cfg_prog_b deasserts.
REQ-002 Parameter LOAD_WORDS, default 1024: post-sync data words required before cfg_done asserts; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_cclk  input  1  selectMAP config clock from the master, asynchronous to clk; oversampled.
REQ-006 cfg_prog_b  input  1  program request, active-low.
REQ-007 cfg_cs_b  input  1  chip select, active-low.
REQ-008 cfg_rdwr_b  input  1  0 = write (master to target), 1 = readback request (unsupported).
REQ-009 cfg_d  input  32  configuration data word.
REQ-010 cfg_init_b  output  1  low = initialising or error; high = ready.
REQ-011 cfg_done  output  1  high = configuration complete.
REQ-012 word_valid  output  1  one-cycle strobe per accepted word.
REQ-013 word_data  output  32  accepted word; valid while word_valid is high.
REQ-014 word_count  output  16  post-sync words accepted.
REQ-015 sync_seen  output  1  sync word detected.
REQ-016 err  output  1  protocol error, sticky until cfg_prog_b low.

Function
REQ-017 All cfg_* inputs pass through a 2-FF synchroniser; a cclk rising edge is detected when synchronised cclk goes 0 to 1.
REQ-018 A word is accepted on a detected cclk edge only if synchronised cs_b=0 and rdwr_b=0; word_valid/word_data are registered 3 clk cycles after the first clk edge sampling cfg_cclk high.
REQ-019 States: RESET, INIT, WAIT_SYNC, LOAD, DONE, ERROR.
REQ-020 Synchronised prog_b=0 in any state -> RESET next cycle; init_b=0, done=0, sync_seen=0, err=0, word_count=0.
REQ-021 RESET -> INIT on synchronised prog_b=1; INIT holds init_b=0 for exactly INIT_CYCLES cycles, then -> WAIT_SYNC with init_b=1.
REQ-022 cclk edges in RESET/INIT are ignored (no word_valid).
REQ-023 WAIT_SYNC: each accepted word pulses word_valid; word equal to 32'hAA995566 sets sync_seen and -> LOAD; word_count stays 0; non-sync words are discarded without error.
REQ-024 LOAD: each accepted word increments word_count; the word making word_count == LOAD_WORDS -> DONE, cfg_done=1 the following cycle.
REQ-025 LOAD: cclk edge with cs_b=0 and rdwr_b=1 -> ERROR: err=1, init_b=0; word not counted.
REQ-026 DONE: further cclk edges ignored; word_valid stays 0; done held until prog_b low.
REQ-027 ERROR: held until prog_b low; no words accepted.
REQ-028 word_count saturates at LOAD_WORDS; never wraps.
REQ-029 prog_b falling in the same cycle as an accepted edge: RESET wins, word dropped.

Reset
REQ-030 rst=1 -> state RESET, outputs: cfg_init_b=0, cfg_done=0, word_valid=0, word_data=0, word_count=0, sync_seen=0, err=0; synchroniser flops cleared (cclk=0, prog_b=0, cs_b=1, rdwr_b=1).
REQ-031 After rst release, the target stays in RESET until synchronised prog_b=1.

Configuration
REQ-032 Macro SS_TARGET_BITSWAP_EN defined: cfg_d bit-swapped within each byte (bit 0 <-> bit 7) before sync compare and word_data; undefined: used as-is.

Structure
REQ-033 Package ss_pkg holds SS_SYNC_WORD (32'hAA995566) and the state enum type.
REQ-034 Sub-module ss_edge_sync: 2-FF synchroniser plus rising-edge detector for cfg_cclk; other inputs synchronised with matching latency.

Verification
REQ-035 rst, prog_b low 5 cycles then high -> init_b low exactly 16 cycles, then high.
REQ-036 After init, write 0xFFFFFFFF, 0xAA995566 -> two word_valid pulses, sync_seen=1 after second, word_count=0.
REQ-037 LOAD_WORDS=4: sync then 4 words -> word_count=4, cfg_done=1; a 5th edge produces no word_valid.
REQ-038 In LOAD after 2 words, rdwr_b=1, cs_b=0, cclk edge -> err=1, init_b=0, word_count stays 2.
REQ-039 prog_b low mid-LOAD -> next cycle all status cleared; reconfiguration completes normally.
REQ-040 With SS_TARGET_BITSWAP_EN, writing 0x5599AA66 achieves sync; without it, it does not.
